// File: rtl/bpu_update_arbiter_pkg.sv
// bpu_update_arbiter_pkg: BPU update record, training-queue entry and queue defaults.
package bpu_update_arbiter_pkg;
  localparam int BPU_UPD_Q_DEPTH = 4;
  typedef struct packed {
    logic        flush;
    logic        btb_update;
    logic        lpht_update;
    logic        taken;
    logic [31:0] pc;
    logic [31:0] br_target;
  } bpu_update_t;
  typedef struct packed {
    bpu_update_t upd;
    logic        from_front;
    logic        kill;
  } bpu_upd_q_entry_t;
  function automatic logic is_train(input bpu_update_t u);
    return !u.flush && (u.btb_update || u.lpht_update);
  endfunction
endpackage

// File: rtl/bpu_update_arbiter_fifo.sv
// bpu_update_arbiter_fifo: 2-write/1-read circular training buffer with kill of front-sourced entries.
module bpu_update_arbiter_fifo
  import bpu_update_arbiter_pkg::*;
#(
  parameter int DEPTH = BPU_UPD_Q_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we0,
  input  bpu_upd_q_entry_t         d0,
  input  logic                     we1,
  input  bpu_upd_q_entry_t         d1,
  input  logic                     re,
  input  logic                     kill_front,
  output bpu_update_t              head_upd,
  output logic                     head_kill,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  bpu_upd_q_entry_t mem [DEPTH];
  logic [AW:0] wp, rp, wp1;
  assign wp1 = wp + {{AW{1'b0}}, we0};
  assign head_upd = mem[rp[AW-1:0]].upd;
  assign head_kill = mem[rp[AW-1:0]].kill;
  assign count = wp - rp;
  // Kill marks land first so a same-cycle write carries its own kill bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) if (kill_front && mem[i].from_front) mem[i].kill <= 1'b1;
      if (we0) mem[wp[AW-1:0]] <= d0;
      if (we1) mem[wp1[AW-1:0]] <= d1;
      wp <= wp1 + {{AW{1'b0}}, we1};
      rp <= rp + {{AW{1'b0}}, re};
    end
  end
endmodule

// File: rtl/bpu_update_arbiter.sv
// bpu_update_arbiter: merges front/back BPU updates onto one port; flushes pass through, training is queued.
// Define BPU_UPD_BYPASS_EN to let a lone training update skip an empty queue in the same cycle.
module bpu_update_arbiter
  import bpu_update_arbiter_pkg::*;
#(
  parameter int DEPTH      = BPU_UPD_Q_DEPTH,
  parameter int DROP_CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  bpu_update_t             update_front_i,
  input  bpu_update_t             update_back_i,
  output bpu_update_t             update_o,
  output logic [$clog2(DEPTH):0]  q_count_o,
  output logic                    busy_o,
  output logic [DROP_CNT_W-1:0]   drop_cnt_o
);
  localparam int CW = $clog2(DEPTH) + 1;
`ifdef BPU_UPD_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  logic train_b, train_f, fl, empty, byp, byp_b, byp_f, want_b, want_f, acc_b, acc_f, pop, head_kill;
  bpu_update_t head_upd, head_out;
  bpu_upd_q_entry_t d0, d1;
  logic [CW:0] free;
  logic [1:0] drop;
  logic [DROP_CNT_W:0] drop_sum;
  assign train_b = is_train(update_back_i);
  assign train_f = is_train(update_front_i);
  assign fl = update_back_i.flush | update_front_i.flush;
  assign empty = q_count_o == '0;
  assign busy_o = ~empty;
  assign byp = BYP & ~fl & empty & (train_b | train_f);
  assign byp_b = byp & train_b;
  assign byp_f = byp & ~train_b;
  assign want_b = train_b & ~byp_b;
  assign want_f = train_f & ~byp_f;
  assign pop = ~fl & ~empty;
  // Slots freed by this cycle's pop are usable by this cycle's pushes.
  assign free = (CW + 1)'(DEPTH) - {1'b0, q_count_o} + {{CW{1'b0}}, pop};
  assign acc_b = want_b & (free != '0);
  assign acc_f = want_f & (free > {{CW{1'b0}}, acc_b});
  assign drop = {1'b0, want_b & ~acc_b} + {1'b0, want_f & ~acc_f};
  assign drop_sum = {1'b0, drop_cnt_o} + {{(DROP_CNT_W - 1){1'b0}}, drop};
  assign d0 = '{upd: update_back_i, from_front: 1'b0, kill: 1'b0};
  assign d1 = '{upd: update_front_i, from_front: 1'b1, kill: update_back_i.flush};
  always_comb begin
    head_out = head_upd;
    head_out.flush = 1'b0;
    update_o = !rst_n ? '0 :
               update_back_i.flush ? update_back_i :
               update_front_i.flush ? update_front_i :
               byp_b ? update_back_i :
               byp_f ? update_front_i :
               (pop & ~head_kill) ? head_out : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_o <= '0;
    else if (drop != 2'd0) drop_cnt_o <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
  end
  bpu_update_arbiter_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .we0        (acc_b),
    .d0         (d0),
    .we1        (acc_f),
    .d1         (d1),
    .re         (pop),
    .kill_front (update_back_i.flush),
    .head_upd   (head_upd),
    .head_kill  (head_kill),
    .count      (q_count_o)
  );
endmodule
